multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Decodes the instruction opcode, sequences fetch, decode, execute, memory and writeback.
- Drives alu_op[1:0] to the ALU control decoder, which turns alu_op plus funct into the 4-bit ALU operation.
- Also drives every datapath mux select and write enable, and stalls on a memory ready handshake.

---
 rtl/multicycle_control_pkg.sv | 94 +++++++++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, alu_op
// encodings, datapath select encodings, FSM states and the control word.
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN (ADDI support).
package multicycle_control_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op encodings shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
`ifdef MULTICYCLE_CTRL_ADDI_EN
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
`else
    S_JUMP      = 4'd9
`endif
  } state_t;

  // Instruction class as seen by the decoder
  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ADDI,
    CLS_ILLEGAL
  } op_class_t;

  // Full control word driven to the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic op_class_t classify(input logic [5:0] op);
    op_class_t cls;
    case (op)
      OP_RTYPE: cls = CLS_R;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_BEQ:   cls = CLS_BEQ;
      OP_J:     cls = CLS_J;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      OP_ADDI:  cls = CLS_ADDI;
`endif
      default:  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives all mux selects and enables.
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN (adds ADDI_EX/ADDI_WB).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op
);

  state_t    state, state_next;
  op_class_t op_cls;
  ctrl_t     ctrl;

  assign op_cls = classify(6'(opcode));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state decode; any unused encoding falls back to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_cls)
          CLS_R:    state_next = S_EXECUTE;
          CLS_LW,
          CLS_SW:   state_next = S_MEM_ADDR;
          CLS_BEQ:  state_next = S_BRANCH;
          CLS_J:    state_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          CLS_ADDI: state_next = S_ADDI_EX;
`endif
          default:  state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_next = (op_cls == CLS_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDI_EX:   state_next = S_ADDI_WB;
      S_ADDI_WB:   state_next = S_FETCH;
`endif
      default:     state_next = S_FETCH;
    endcase
  end

  // Output decode: Moore from state, except FETCH's ir_write/pc_write which
  // follow mem_ready; reset gates every output to zero combinationally
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (op_cls == CLS_ILLEGAL);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
    if (reset) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALUOP_W'(ctrl.alu_op);
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction scenarios
// followed by randomized instructions and mem_ready stalls, checked against an
// instruction-level phase model.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } outs_t;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE,
    P_EXECUTE, P_R_WB, P_BRANCH, P_JUMP, P_ADDI_EX, P_ADDI_WB
  } ph_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  outs_t      obs;

  int total = 0;
  int bad   = 0;
  ph_t seq[$];

  always #5 clk = ~clk;

  multicycle_control #(.OPC_W(6), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  function automatic bit legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
`ifdef MULTICYCLE_CTRL_ADDI_EN
    ok = ok || (op == 6'd8);
`endif
    return ok;
  endfunction

  // Phases an instruction walks through, from the instruction's point of view
  function automatic void build(input logic [5:0] op);
    seq.delete();
    seq.push_back(P_FETCH);
    seq.push_back(P_DECODE);
    if (legal(op)) begin
      case (op)
        6'd0:  begin seq.push_back(P_EXECUTE); seq.push_back(P_R_WB); end
        6'd35: begin seq.push_back(P_MEM_ADDR); seq.push_back(P_MEM_READ); seq.push_back(P_MEM_WB); end
        6'd43: begin seq.push_back(P_MEM_ADDR); seq.push_back(P_MEM_WRITE); end
        6'd4:  seq.push_back(P_BRANCH);
        6'd2:  seq.push_back(P_JUMP);
        6'd8:  begin seq.push_back(P_ADDI_EX); seq.push_back(P_ADDI_WB); end
        default: ;
      endcase
    end
  endfunction

  function automatic bit waits(input ph_t p);
    return (p == P_FETCH) || (p == P_MEM_READ) || (p == P_MEM_WRITE);
  endfunction

  function automatic outs_t exp_out(input ph_t p, input logic mr, input logic [5:0] op);
    outs_t o;
    o = '0;
    case (p)
      P_FETCH:     begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      P_DECODE:    begin o.alu_src_b = 2'b11; o.illegal_op = !legal(op); end
      P_MEM_ADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MEM_READ:  begin o.mem_read = 1; o.i_or_d = 1; end
      P_MEM_WB:    begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MEM_WRITE: begin o.mem_write = 1; o.i_or_d = 1; end
      P_EXECUTE:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      P_R_WB:      begin o.reg_write = 1; o.reg_dst = 1; end
      P_BRANCH:    begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      P_JUMP:      begin o.pc_write = 1; o.pc_source = 2'b10; end
      P_ADDI_EX:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_ADDI_WB:   o.reg_write = 1;
      default:     o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input outs_t e, input string tag);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  // Runs one instruction from FETCH; abort_idx >= 0 asserts reset in that phase
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input bit rnd, input int abort_idx);
    int  stalls;
    bit  w;
    logic mr;
    build(op);
    opcode = op;
    for (int i = 0; i < seq.size(); i++) begin
      w = waits(seq[i]);
      stalls = (seq[i] == P_FETCH) ? fstall : mstall;
      if (i == abort_idx) begin
        reset = 1'b1;
        mem_ready = 1'($urandom);
        @(negedge clk);
        check('0, $sformatf("abort_ph%0d_op%0h", i, op));
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      forever begin
        if (!w) mr = 1'($urandom);
        else if (rnd) mr = (($urandom % 3) != 0);
        else if (stalls > 0) begin mr = 1'b0; stalls--; end
        else mr = 1'b1;
        mem_ready = mr;
        @(negedge clk);
        check(exp_out(seq[i], mr, op), $sformatf("ph%0d_op%0h_mr%0d", i, op, mr));
        @(posedge clk); #1;
        if (!w || mr) break;
      end
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'd0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      check('0, "reset_zero");
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b000000, 0, 0, 0, -1);   // R-type
    run_instr(6'b100011, 0, 3, 0, -1);   // LW with 3 stall cycles in MEM_READ
    run_instr(6'b101011, 2, 0, 0, -1);   // SW with 2 stall cycles in FETCH
    run_instr(6'b000100, 0, 0, 0, -1);   // BEQ
    run_instr(6'b000010, 0, 0, 0, -1);   // J
    run_instr(6'b111111, 0, 0, 0, -1);   // illegal
    run_instr(6'b001000, 0, 0, 0, -1);   // ADDI (legal only with feature)
    run_instr(6'b100011, 0, 0, 0, 3);    // reset while in MEM_READ
    run_instr(6'b101011, 0, 1, 0, 3);    // reset while in MEM_WRITE
    run_instr(6'b000000, 1, 0, 0, -1);   // FETCH resumes after abort

    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom % 8);
      if (r < 6) op = ops[r];
      else op = 6'($urandom);
      run_instr(op, 0, 0, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
